// File: rtl/multiseg_capture_if.sv
// Bus between a multiplexed 7-segment display scanner and the frame capture block.
interface multiseg_capture_if;
    logic [3:0]  seg_anode;
    logic [6:0]  seg_cathode;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        pattern_err;

    modport master (
        output seg_anode,
        output seg_cathode,
        input  bcd_out,
        input  frame_valid,
        input  pattern_err
    );

    modport slave (
        input  seg_anode,
        input  seg_cathode,
        output bcd_out,
        output frame_valid,
        output pattern_err
    );
endinterface

// File: rtl/multiseg_capture.sv
// Recovers a 4-digit BCD frame by snooping a multiplexed 7-segment display drive.
// Define SEGCAP_HEX_EN to also decode the hex letters A..F.
module multiseg_capture #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    multiseg_capture_if.slave  bus
);
    localparam int unsigned SEG_W = 11;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0] r_sync1;
    logic [SEG_W-1:0] r_sync2;
    logic [SEG_W-1:0] r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             r_captured;
    logic [3:0]       r_mask;
    logic [3:0][3:0]  r_shadow;
    logic [15:0]      r_bcd;
    logic             r_fv;
    logic             r_err;

    logic [3:0]       w_anode;
    logic [6:0]       w_cathode;
    logic             w_changed;
    logic             w_capture;
    logic [1:0]       w_digit;
    logic             w_one_cold;
    logic [4:0]       w_dec;
    logic [3:0]       w_digit_bit;
    logic [3:0]       w_mask_nxt;
    logic [3:0][3:0]  w_shadow_nxt;
    logic             w_fv_nxt;
    logic             w_err_nxt;

    // Returns {decodable, nibble} for an active-low {g..a} cathode pattern.
    function automatic logic [4:0] f_decode(input logic [6:0] cat);
        logic [4:0] res;
        res = 5'h00;
        case (cat)
            7'h40: res = 5'h10;
            7'h79: res = 5'h11;
            7'h24: res = 5'h12;
            7'h30: res = 5'h13;
            7'h19: res = 5'h14;
            7'h12: res = 5'h15;
            7'h02: res = 5'h16;
            7'h78: res = 5'h17;
            7'h00: res = 5'h18;
            7'h10: res = 5'h19;
`ifdef SEGCAP_HEX_EN
            7'h08: res = 5'h1A;
            7'h03: res = 5'h1B;
            7'h46: res = 5'h1C;
            7'h21: res = 5'h1D;
            7'h06: res = 5'h1E;
            7'h0E: res = 5'h1F;
`else
`endif
            default: res = 5'h00;
        endcase
        return res;
    endfunction

    // Pins are asynchronous to clk; blank (all-ones) is the safe reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
        end else begin
            r_sync1 <= {bus.seg_anode, bus.seg_cathode};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_anode   = r_sync2[10:7];
    assign w_cathode = r_sync2[6:0];
    assign w_changed = (r_sync2 != r_prev);
    assign w_capture = !w_changed && (r_cnt == CNT_MAX) && !r_captured;
    assign w_dec     = f_decode(w_cathode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_captured <= 1'b0;
        end else if (w_changed) begin
            r_cnt      <= '0;
            r_captured <= 1'b0;
        end else begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
            if (w_capture)        r_captured <= 1'b1;
        end
    end

    always_comb begin
        w_digit    = 2'd0;
        w_one_cold = 1'b1;
        case (w_anode)
            4'hE:    w_digit = 2'd0;
            4'hD:    w_digit = 2'd1;
            4'hB:    w_digit = 2'd2;
            4'h7:    w_digit = 2'd3;
            default: w_one_cold = 1'b0;
        endcase
    end

    assign w_digit_bit = ~w_anode;

    // Shadow/mask update; a frame commits the moment the last missing digit lands.
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_mask_nxt   = r_mask;
        w_fv_nxt     = 1'b0;
        w_err_nxt    = 1'b0;
        if (w_capture && w_one_cold) begin
            if (w_dec[4]) begin
                w_shadow_nxt[w_digit] = w_dec[3:0];
                w_mask_nxt            = r_mask | w_digit_bit;
                if (w_mask_nxt == 4'hF) begin
                    w_fv_nxt   = 1'b1;
                    w_mask_nxt = 4'h0;
                end
            end else begin
                w_err_nxt  = 1'b1;
                w_mask_nxt = r_mask & ~w_digit_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
            r_mask   <= '0;
            r_bcd    <= '0;
            r_fv     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_shadow <= w_shadow_nxt;
            r_mask   <= w_mask_nxt;
            r_fv     <= w_fv_nxt;
            r_err    <= w_err_nxt;
            if (w_fv_nxt) r_bcd <= w_shadow_nxt;
        end
    end

    assign bus.bcd_out     = r_bcd;
    assign bus.frame_valid = r_fv;
    assign bus.pattern_err = r_err;
endmodule
